// File: rtl/clink_pkg.sv
// Shared C-link constants and the frame packer state encoding.
// The receive checker uses the same CRC parameters.
package clink_pkg;

  localparam int HDR_LEN     = 8;
  localparam int DEF_MAX_PAY = 2037;
  localparam int DEF_GAP_CYC = 64;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PAY   = 3'd2,
    ST_CRC_H = 3'd3,
    ST_CRC_L = 3'd4,
    ST_START = 3'd5
  } pack_state_e;

endpackage

// File: rtl/clink_crc16.sv
// Byte-wide combinational CRC16-CCITT step (MSB first, no reflection).
module clink_crc16
  import clink_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc_out
);

  // Shift one byte through the polynomial division, MSB first.
  always_comb begin
    crc_out = crc_in ^ {data_byte, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[15]) crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else             crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/clink_frame_packer.sv
// C-link transmit frame builder: header, payload from ch1 TX RAM and CRC16
// written into the link TX buffer, followed by a tx_start pulse.
module clink_frame_packer
  import clink_pkg::*;
#(
  parameter int MAX_PAY = DEF_MAX_PAY,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        ini_done,
  input  logic [3:0]  station_id,
  input  logic [3:0]  slot_id,
  input  logic        da_valid,
  input  logic [23:0] ch1_da,
  input  logic [10:0] ch1_pay_len,
  output logic        ch1_txbuf_rden,
  output logic [10:0] ch1_txbuf_raddr,
  input  logic [7:0]  ch1_txbuf_rdata,
  output logic        tx_buf_wren,
  output logic [10:0] tx_buf_waddr,
  output logic [7:0]  tx_buf_wdata,
  output logic [10:0] tx_data_len,
  output logic        tx_start,
  output logic        tx_busy,
  output logic        tx_drop,
  output logic        tx_len_err,
  output logic [15:0] tx_sn
);

  localparam logic [10:0] MAX_PAY_L = 11'(MAX_PAY);
  localparam logic [10:0] HDR_LAST  = 11'(HDR_LEN - 1);
  localparam logic [10:0] FRM_EXTRA = 11'(HDR_LEN + 2);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC - 1);

  pack_state_e state, state_nxt;
  logic [10:0] cnt;
  logic [23:0] da_r;
  logic [10:0] pay_len_r;
  logic [7:0]  sa_r;
  logic [15:0] crc_r, crc_nxt, sn_r, gap_cnt;
  logic [10:0] data_len_r;
  logic        drop_r, len_err_r;
  logic [7:0]  hdr_byte, crc_byte;
  logic        accept_ok, accept, reject_len;

  assign accept_ok  = (state == ST_IDLE) && (gap_cnt == 16'd0) && ini_done;
  assign reject_len = da_valid && accept_ok && (ch1_pay_len > MAX_PAY_L);
  assign accept     = da_valid && accept_ok && (ch1_pay_len <= MAX_PAY_L);

  // Header byte selected by the running header index.
  always_comb begin
    case (cnt[2:0])
      3'd0:    hdr_byte = da_r[23:16];
      3'd1:    hdr_byte = da_r[15:8];
      3'd2:    hdr_byte = da_r[7:0];
      3'd3:    hdr_byte = sa_r;
      3'd4:    hdr_byte = sn_r[15:8];
      3'd5:    hdr_byte = sn_r[7:0];
      3'd6:    hdr_byte = {5'b00000, pay_len_r[10:8]};
      3'd7:    hdr_byte = pay_len_r[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  assign crc_byte = (state == ST_PAY) ? ch1_txbuf_rdata : hdr_byte;

  clink_crc16 u_crc (
    .crc_in   (crc_r),
    .data_byte(crc_byte),
    .crc_out  (crc_nxt)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; PAY is skipped for empty payloads.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_HDR;
        else        state_nxt = ST_IDLE;
      end
      ST_HDR: begin
        if (cnt != HDR_LAST)           state_nxt = ST_HDR;
        else if (pay_len_r == 11'd0)   state_nxt = ST_CRC_H;
        else                           state_nxt = ST_PAY;
      end
      ST_PAY: begin
        if (cnt == pay_len_r - 11'd1) state_nxt = ST_CRC_H;
        else                          state_nxt = ST_PAY;
      end
      ST_CRC_H: state_nxt = ST_CRC_L;
      ST_CRC_L: state_nxt = ST_START;
      ST_START: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: latched request fields, CRC, SN, gap counter and pulses.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt        <= 11'd0;
      da_r       <= 24'd0;
      pay_len_r  <= 11'd0;
      sa_r       <= 8'd0;
      crc_r      <= CRC_INIT;
      sn_r       <= 16'd0;
      gap_cnt    <= 16'd0;
      data_len_r <= 11'd0;
      drop_r     <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      drop_r    <= da_valid && !accept_ok;
      len_err_r <= reject_len;
      if ((state_nxt == state) && ((state == ST_HDR) || (state == ST_PAY))) cnt <= cnt + 11'd1;
      else                                                                  cnt <= 11'd0;
      if (accept) begin
        da_r      <= ch1_da;
        pay_len_r <= ch1_pay_len;
        sa_r      <= {station_id, slot_id};
        crc_r     <= CRC_INIT;
      end else if ((state == ST_HDR) || (state == ST_PAY)) begin
        crc_r <= crc_nxt;
      end
      if (state == ST_CRC_L) data_len_r <= pay_len_r + FRM_EXTRA;
      // The gap reload on tx_start overrides the decrement.
      if (state == ST_START) begin
        sn_r    <= sn_r + 16'd1;
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != 16'd0) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

  // Buffer/RAM strobes; the payload read for byte k+1 overlaps the write of byte k.
  always_comb begin
    tx_buf_wren     = 1'b0;
    tx_buf_waddr    = 11'd0;
    tx_buf_wdata    = 8'h00;
    ch1_txbuf_rden  = 1'b0;
    ch1_txbuf_raddr = 11'd0;
    tx_start        = 1'b0;
    case (state)
      ST_HDR: begin
        tx_buf_wren    = 1'b1;
        tx_buf_waddr   = cnt;
        tx_buf_wdata   = hdr_byte;
        ch1_txbuf_rden = (cnt == HDR_LAST) && (pay_len_r != 11'd0);
      end
      ST_PAY: begin
        tx_buf_wren  = 1'b1;
        tx_buf_waddr = cnt + 11'(HDR_LEN);
        tx_buf_wdata = ch1_txbuf_rdata;
        if (cnt + 11'd1 < pay_len_r) begin
          ch1_txbuf_rden  = 1'b1;
          ch1_txbuf_raddr = cnt + 11'd1;
        end else begin
          ch1_txbuf_rden  = 1'b0;
        end
      end
      ST_CRC_H: begin
        tx_buf_wren  = 1'b1;
        tx_buf_waddr = pay_len_r + 11'(HDR_LEN);
        tx_buf_wdata = crc_r[15:8];
      end
      ST_CRC_L: begin
        tx_buf_wren  = 1'b1;
        tx_buf_waddr = pay_len_r + 11'(HDR_LEN + 1);
        tx_buf_wdata = crc_r[7:0];
      end
      ST_START: tx_start = 1'b1;
      default:  tx_start = 1'b0;
    endcase
  end

  assign tx_busy     = (state != ST_IDLE);
  assign tx_data_len = data_len_r;
  assign tx_sn       = sn_r;
  assign tx_drop     = drop_r;
  assign tx_len_err  = len_err_r;

endmodule
